// File: rtl/radix4_booth_seq_mult.sv
// Iterative unsigned radix-4 Booth multiplier, one digit per clock, with optional
// low-column truncation. Define RADIX4_APPROX_COMP_EN to add truncation bias compensation.
module radix4_booth_seq_mult #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned APPROX_COLS = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               approx_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int unsigned PW         = 2 * WIDTH;
    localparam int unsigned NUM_DIGITS = WIDTH / 2 + 1;
    localparam int unsigned BW         = WIDTH + 3;
    localparam int unsigned CW         = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    // Columns kept after truncation; all ones when APPROX_COLS is zero.
    localparam logic [PW-1:0] KEEP_MASK  = {PW{1'b1}} << APPROX_COLS;
`ifdef RADIX4_APPROX_COMP_EN
    localparam logic [PW-1:0] COMP = (APPROX_COLS > 0) ?
                                     (PW'(NUM_DIGITS) << (APPROX_COLS - 1)) : '0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   mcand_q;
    logic [BW-1:0]   mult_q;
    logic            approx_q;
    logic [PW-1:0]   acc_q;

    logic [2:0]      digit;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   acc_next;
    logic            last_digit;

    assign P          = acc_q;
    assign last_digit = (cnt_q == LAST_DIGIT);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // mult_q[2:0] is {b[2i+1], b[2i], b[2i-1]} for the current digit.
    assign digit = mult_q[2:0];

    always_comb begin
        pp = '0;
        case (digit)
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
        if (approx_q) begin
            pp = pp & KEEP_MASK;
        end
    end

    always_comb begin
        acc_next = acc_q + pp;
`ifdef RADIX4_APPROX_COMP_EN
        if (approx_q && last_digit) begin
            acc_next = acc_next + COMP;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mult_q   <= '0;
            approx_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && in_valid) begin
                mcand_q  <= {{WIDTH{1'b0}}, A};
                mult_q   <= {2'b00, B, 1'b0};
                approx_q <= approx_en;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state_q == StBusy) begin
                acc_q   <= acc_next;
                mcand_q <= mcand_q << 2;
                mult_q  <= mult_q >> 2;
                cnt_q   <= last_digit ? '0 : cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_radix4_booth_seq_mult.sv
// Scoreboard bench for radix4_booth_seq_mult (WIDTH=32, APPROX_COLS=16).
module tb_radix4_booth_seq_mult;

    localparam int W  = 32;
    localparam int AC = 16;
    localparam int ND = W / 2 + 1;
`ifdef RADIX4_APPROX_COMP_EN
    localparam logic [63:0] COMP = 64'(ND) << (AC - 1);
`else
    localparam logic [63:0] COMP = 64'd0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        approx_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] P;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    radix4_booth_seq_mult #(
        .WIDTH      (W),
        .APPROX_COLS(AC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .P        (P),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic ap);
        logic [34:0] be;
        logic [63:0] sum, pp, mask;
        int d;
        be   = {2'b00, b, 1'b0};
        mask = ~64'd0 << AC;
        sum  = '0;
        for (int i = 0; i < ND; i++) begin
            d  = -2 * int'(be[2*i+2]) + int'(be[2*i+1]) + int'(be[2*i]);
            pp = 64'(longint'(d) * longint'({32'd0, a})) << (2 * i);
            if (ap) pp = pp & mask;
            sum = sum + pp;
        end
        if (ap) sum = sum + COMP;
        return sum;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ap,
                         input logic [63:0] exp);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_issue", 64'(in_ready), 64'd1);
        A = a; B = b; approx_en = ap; in_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; approx_en = 1'($urandom);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'd17);
    endtask

    task automatic collect();
        logic [63:0] e;
        wait_out();
        e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        chk("P", P, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_clear", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] e;
        logic [31:0] a, b;
        logic seen;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_P", P, 64'd0);

        // Directed corners
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);
        collect();
        issue(32'd3, 32'd5, 1'b1, 64'd0 + COMP);
        collect();
        issue(32'd3, 32'd5, 1'b0, 64'd15);
        collect();
        issue(32'd1, 32'd2, 1'b1, 64'hFFFFFFFFFFFF0000 + COMP);
        collect();
        issue(32'd1, 32'd2, 1'b0, 64'd2);
        collect();
        issue(32'd0, 32'hDEADBEEF, 1'b1, COMP);
        collect();
        issue(32'hCAFEF00D, 32'd0, 1'b0, 64'd0);
        collect();

        // Backpressure
        issue(32'd1000, 32'd1000, 1'b0, 64'd1000000);
        wait_out();
        e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        for (int k = 0; k < 10; k++) begin
            chk("bp_P", P, e);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            in_valid = k[0];
            A = $urandom; B = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; A = 32'd5; B = 32'd5; out_ready = 1'b1;
        chk("bp_P_final", P, e);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);

        // Reset mid-operation
        A = 32'h12345678; B = 32'h9ABCDEF0; approx_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_P", P, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            seen = seen | out_valid;
            @(posedge clk); #1;
        end
        chk("mid_no_out_valid", 64'(seen), 64'd0);
        issue(32'd7, 32'd6, 1'b0, 64'd42);
        collect();

        // Random regression
        for (int k = 0; k < 500; k++) begin
            a = $urandom; b = $urandom;
            issue(a, b, 1'b0, {32'd0, a} * {32'd0, b});
            collect();
        end
        for (int k = 0; k < 500; k++) begin
            a = $urandom; b = $urandom;
            issue(a, b, 1'b1, ref_model(a, b, 1'b1));
            collect();
        end

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
